fsk_frame_rx: RTL and testbench

- Downstream consumer of the UART receive path.
- Pops bytes from the UART RX FIFO and parses framed packets of the form SYNC, LEN, PAYLOAD[LEN], CSUM.
- Buffers the payload and checks the checksum.
- On a good frame, streams the payload MSB-first, one bit at a time, to the FSK modulator over a valid/ready handshake. Bad frames are dropped and flagged.

---
 rtl/fsk_frame_rx_pkg.sv | 15 +
 rtl/fsk_frame_rx_frame_buf.sv | 30 +++
 rtl/fsk_frame_rx.sv | 168 ++++++++++++++++
 tb/tb_fsk_frame_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_frame_rx_pkg.sv
// Shared definitions for the FSK frame receiver: parser/serializer state
// encoding and the default frame start byte.
package fsk_frame_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_SEND    = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage : fsk_frame_rx_pkg

// File: rtl/fsk_frame_rx_frame_buf.sv
// Payload buffer: simple dual-port 8 x 2^ADDR_W RAM, synchronous write,
// registered read.
//   clk   in   clock
//   we    in   write enable
//   waddr in   write address
//   wdata in   write byte
//   raddr in   read address (sampled on clk)
//   rdata out  registered read byte
module fsk_frame_rx_frame_buf #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [7:0] mem [DEPTH];

  // Storage array carries no reset; contents are always written before read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule : fsk_frame_rx_frame_buf

// File: rtl/fsk_frame_rx.sv
// Framed-packet receiver between the UART RX FIFO and the FSK modulator.
// Parses SYNC, LEN, PAYLOAD[LEN], CSUM; buffers the payload, verifies the XOR
// checksum and streams good payloads MSB-first over a valid/ready handshake.
//   clk, reset           clock, async active-high reset
//   rx_empty, r_data     RX FIFO empty flag and head byte
//   rd_uart              combinational FIFO pop strobe
//   bit_out, bit_valid   payload bit stream to modulator
//   bit_ready            modulator accept
//   busy                 not idle
//   frame_done           pulse after last bit of a good frame
//   frame_err            pulse on a dropped frame
module fsk_frame_rx
  import fsk_frame_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC    = SYNC_DEFAULT,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned TO_BIT  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int unsigned IDX_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [TO_BIT-1:0] to_cnt_q, to_cnt_d;
  logic              done_d, err_d;
  logic              we;
  logic [7:0]        rdata;
  logic              accept;

  // Pop whenever data is present, except while serializing.
  assign rd_uart = ~rx_empty & (state_q != ST_SEND);
  assign accept  = bit_valid & bit_ready;
  // Gated so bit_out is 0 outside SEND, where the RAM output is don't-care.
  assign bit_out = bit_valid & rdata[bit_idx_q];

  // Read address follows the next rd_idx so rdata is current on every SEND cycle.
  fsk_frame_rx_frame_buf #(.ADDR_W(ADDR_W)) u_frame_buf (
    .clk   (clk),
    .we    (we),
    .waddr (wr_idx_q[ADDR_W-1:0]),
    .wdata (r_data),
    .raddr (rd_idx_d[ADDR_W-1:0]),
    .rdata (rdata)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      csum_q     <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      bit_idx_q  <= '0;
      to_cnt_q   <= '0;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      bit_idx_q  <= bit_idx_d;
      to_cnt_q   <= to_cnt_d;
      bit_valid  <= (state_d == ST_SEND);
      busy       <= (state_d != ST_IDLE);
      frame_done <= done_d;
      frame_err  <= err_d;
    end
  end

  // Parser / serializer next-state logic.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    csum_d    = csum_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    bit_idx_d = bit_idx_q;
    to_cnt_d  = to_cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    we        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        to_cnt_d = '0;
        if (rd_uart && (r_data == SYNC)) state_d = ST_LEN;
      end

      ST_LEN, ST_PAYLOAD, ST_CSUM: begin
        if (rd_uart) begin
          to_cnt_d = '0;
          if (state_q == ST_LEN) begin
            len_d  = r_data;
            csum_d = r_data;
            if ((r_data == 8'd0) || (r_data > 8'(MAX_LEN))) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              wr_idx_d = '0;
              state_d  = ST_PAYLOAD;
            end
          end else if (state_q == ST_PAYLOAD) begin
            we       = 1'b1;
            csum_d   = csum_q ^ r_data;
            wr_idx_d = wr_idx_q + IDX_W'(1);
            if ((wr_idx_q + IDX_W'(1)) == IDX_W'(len_q)) state_d = ST_CSUM;
          end else begin
            if (r_data == csum_q) begin
              rd_idx_d  = '0;
              bit_idx_d = 3'd7;
              state_d   = ST_SEND;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end else if (to_cnt_q == TO_BIT'(TIMEOUT - 2)) begin
          // This edge would bring the count to TIMEOUT-1: abandon the frame.
          to_cnt_d = '0;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_BIT'(1);
        end
      end

      ST_SEND: begin
        to_cnt_d = '0;
        if (accept) begin
          bit_idx_d = bit_idx_q - 3'd1;
          if (bit_idx_q == 3'd0) begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
            if ((rd_idx_q + IDX_W'(1)) == IDX_W'(len_q)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule : fsk_frame_rx

// File: tb/tb_fsk_frame_rx.sv
// Self-checking bench for fsk_frame_rx: models the RX FIFO as a byte queue,
// pushes expected payload bits to a scoreboard and compares accepted bits.
module tb_fsk_frame_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready = 1'b1;
  logic       busy;
  logic       frame_done;
  logic       frame_err;

  fsk_frame_rx #(.TIMEOUT(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .r_data     (r_data),
    .rd_uart    (rd_uart),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo [$];
  logic       exp_bits [$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, pop_cnt = 0, last_pop = 0;
  int done_cnt = 0, err_cnt = 0, err_cyc = 0;
  int acc_cnt = 0, valid_cycles = 0;
  logic will_pop = 1'b0;
  logic stall_mode = 1'b0, stall_prev = 1'b0, prev_bit = 1'b0;
  logic [3:0] pat = 4'b1001;
  int ptr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic exp_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  // Wait until the FIFO is drained and the receiver is idle again.
  task automatic wait_quiet(input string tag);
    int n = 0;
    @(negedge clk);
    while ((fifo.size() != 0 || busy || !rx_empty) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check({tag, "_hang"}, 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // FIFO pop on the edge where rd_uart was seen high, then refresh the head.
  always @(posedge clk) begin
    cyc++;
    if (will_pop && !reset && fifo.size() != 0) begin
      void'(fifo.pop_front());
      pop_cnt++;
      last_pop = cyc;
    end
    #1;
    rx_empty = (fifo.size() == 0);
    r_data   = rx_empty ? 8'h00 : fifo[0];
  end

  // Monitor: handshake scoreboard, stall stability, pulse bookkeeping.
  always @(negedge clk) begin
    logic eb;
    will_pop = rd_uart & ~reset;
    if (!reset) begin
      if (stall_prev) begin
        check("stall_valid", 32'(bit_valid), 32'd1);
        check("stall_bit", 32'(bit_out), 32'(prev_bit));
      end
      if (stall_mode) begin
        bit_ready = pat[ptr];
        ptr = (ptr + 1) % 4;
      end else begin
        bit_ready = 1'b1;
      end
      if (bit_valid) valid_cycles++;
      if (bit_valid && bit_ready) begin
        acc_cnt++;
        if (exp_bits.size() == 0) check("extra_bit", 32'd1, 32'd0);
        else begin
          eb = exp_bits.pop_front();
          check("bit", 32'(bit_out), 32'(eb));
        end
      end
      stall_prev = bit_valid & ~bit_ready;
      prev_bit   = bit_out;
      if (frame_done) done_cnt++;
      if (frame_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (frame_done || frame_err) check("pulse_excl", 32'(frame_done & frame_err), 32'd0);
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    int d0, e0, p0, v0, a0, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_uart", 32'(rd_uart), 32'd0);
    check("rst_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_bit_out", 32'(bit_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    reset = 1'b0;

    // Good frame
    d0 = done_cnt; e0 = err_cnt; p0 = pop_cnt; v0 = valid_cycles;
    push(8'hA5); push(8'h02); push(8'hC3); push(8'h3C); push(8'hFD);
    exp_byte(8'hC3); exp_byte(8'h3C);
    wait_quiet("good");
    check("good_pops", 32'(pop_cnt - p0), 32'd5);
    check("good_done", 32'(done_cnt - d0), 32'd1);
    check("good_err", 32'(err_cnt - e0), 32'd0);
    check("good_valid_cycles", 32'(valid_cycles - v0), 32'd16);
    check("good_sb_empty", 32'(exp_bits.size()), 32'd0);

    // Bad checksum
    d0 = done_cnt; e0 = err_cnt; v0 = valid_cycles;
    push(8'hA5); push(8'h01); push(8'h55); push(8'h00);
    wait_quiet("badcs");
    check("badcs_err", 32'(err_cnt - e0), 32'd1);
    check("badcs_err_edge", 32'(err_cyc - last_pop), 32'd0);
    check("badcs_done", 32'(done_cnt - d0), 32'd0);
    check("badcs_valid", 32'(valid_cycles - v0), 32'd0);
    check("badcs_busy", 32'(busy), 32'd0);

    // Length bounds followed by a good one-byte frame
    d0 = done_cnt; e0 = err_cnt; p0 = pop_cnt;
    push(8'hA5); push(8'h00);
    push(8'hA5); push(8'h11);
    push(8'hA5); push(8'h01); push(8'h80); push(8'h81);
    exp_byte(8'h80);
    wait_quiet("len");
    check("len_err", 32'(err_cnt - e0), 32'd2);
    check("len_done", 32'(done_cnt - d0), 32'd1);
    check("len_pops", 32'(pop_cnt - p0), 32'd8);
    check("len_sb_empty", 32'(exp_bits.size()), 32'd0);

    // Garbage prefix with back-pressure
    d0 = done_cnt; e0 = err_cnt; p0 = pop_cnt; a0 = acc_cnt;
    stall_mode = 1'b1; ptr = 0;
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h01); push(8'hF0); push(8'hF1);
    exp_byte(8'hF0);
    wait_quiet("bp");
    stall_mode = 1'b0;
    check("bp_pops", 32'(pop_cnt - p0), 32'd6);
    check("bp_accepted", 32'(acc_cnt - a0), 32'd8);
    check("bp_done", 32'(done_cnt - d0), 32'd1);
    check("bp_err", 32'(err_cnt - e0), 32'd0);

    // Inter-byte timeout, then recovery
    d0 = done_cnt; e0 = err_cnt;
    push(8'hA5); push(8'h02); push(8'h11);
    wait_quiet("to");
    check("to_err", 32'(err_cnt - e0), 32'd1);
    check("to_delay", 32'(err_cyc - last_pop), 32'd19);
    check("to_done", 32'(done_cnt - d0), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
    push(8'hA5); push(8'h01); push(8'h80); push(8'h81);
    exp_byte(8'h80);
    wait_quiet("to_rec");
    check("to_rec_done", 32'(done_cnt - d0), 32'd1);
    check("to_rec_err", 32'(err_cnt - e0), 32'd1);

    // Reset in the middle of SEND
    d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
    push(8'hA5); push(8'h02); push(8'hC3); push(8'h3C); push(8'hFD);
    exp_byte(8'hC3); exp_byte(8'h3C);
    n = 0;
    while (acc_cnt < a0 + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("mrst_hang", 32'd1, 32'd0);
    @(posedge clk);
    #2;
    check("mrst_pre_valid", 32'(bit_valid), 32'd1);
    reset = 1'b1;
    fifo.delete();
    exp_bits.delete();
    #1;
    check("mrst_valid", 32'(bit_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(frame_done), 32'd0);
    check("mrst_err", 32'(frame_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mrst_no_err", 32'(err_cnt - e0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fsk_frame_rx
